// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline <-> hazard controller signal bundle
// Purpose: groups the ID/EX/MEM hazard inputs and the PC/stage control
//          outputs of hazard_ctrl into one interface.
// Modports:
//   master - pipeline side: drives id_*/ex_*/mem_*/redirect_* inputs,
//            observes pc_*, stage stall/flush/bubble, fwd selects, perf counters
//   slave  - hazard_ctrl side (mirror of master)
interface hazard_ctrl_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CPU_WIDTH      = 32,
  parameter int CNT_WIDTH      = 32
);
  logic                      id_valid_i;
  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr_i;
  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr_i;
  logic                      id_rs1_used_i;
  logic                      id_rs2_used_i;
  logic                      id_wen_i;
  logic [REG_ADDR_WIDTH-1:0] id_waddr_i;
  logic                      id_is_load_i;
  logic                      ex_wen_i;
  logic [REG_ADDR_WIDTH-1:0] ex_waddr_i;
  logic                      mem_wen_i;
  logic [REG_ADDR_WIDTH-1:0] mem_waddr_i;
  logic                      ex_busy_i;
  logic                      redirect_i;
  logic [CPU_WIDTH-1:0]      redirect_pc_i;

  logic                      pc_ena_o;
  logic                      pc_sel_o;
  logic [CPU_WIDTH-1:0]      redirect_pc_o;
  logic                      if_id_stall_o;
  logic                      if_id_flush_o;
  logic                      id_ex_stall_o;
  logic                      id_ex_bubble_o;
  logic                      ex_mem_bubble_o;
  logic [1:0]                fwd_rs1_sel_o;
  logic [1:0]                fwd_rs2_sel_o;
  logic [CNT_WIDTH-1:0]      perf_lu_cnt_o;
  logic [CNT_WIDTH-1:0]      perf_fl_cnt_o;
  logic [CNT_WIDTH-1:0]      perf_busy_cnt_o;

  modport master (
    output id_valid_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
           id_wen_i, id_waddr_i, id_is_load_i, ex_wen_i, ex_waddr_i,
           mem_wen_i, mem_waddr_i, ex_busy_i, redirect_i, redirect_pc_i,
    input  pc_ena_o, pc_sel_o, redirect_pc_o, if_id_stall_o, if_id_flush_o,
           id_ex_stall_o, id_ex_bubble_o, ex_mem_bubble_o, fwd_rs1_sel_o,
           fwd_rs2_sel_o, perf_lu_cnt_o, perf_fl_cnt_o, perf_busy_cnt_o
  );

  modport slave (
    input  id_valid_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
           id_wen_i, id_waddr_i, id_is_load_i, ex_wen_i, ex_waddr_i,
           mem_wen_i, mem_waddr_i, ex_busy_i, redirect_i, redirect_pc_i,
    output pc_ena_o, pc_sel_o, redirect_pc_o, if_id_stall_o, if_id_flush_o,
           id_ex_stall_o, id_ex_bubble_o, ex_mem_bubble_o, fwd_rs1_sel_o,
           fwd_rs2_sel_o, perf_lu_cnt_o, perf_fl_cnt_o, perf_busy_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - hazard/stall/flush controller for the 5-stage core
// Purpose: load-use scoreboard, registered EX forwarding selects, multi-cycle
//          EX stall and branch/jump redirect flush; drives PC enable and
//          per-stage stall/bubble controls.
//          Priority: busy > redirect > load-use > normal.
// Optional feature: define HAZARD_PERF_CNT_EN to build saturating perf
//          counters; otherwise perf_*_o are tied to 0.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - hazard_ctrl_if.slave (ID/EX/MEM hazard inputs, control outputs)
module hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CPU_WIDTH      = 32,
  parameter int LOAD_LAT       = 1,
  parameter int CNT_WIDTH      = 32
) (
  input logic          clk,
  input logic          rst_n,
  hazard_ctrl_if.slave bus
);
  localparam int         NUM_REGS = 2 ** REG_ADDR_WIDTH;
  localparam logic [2:0] SB_INIT  = 3'(LOAD_LAT);

  // Per-register countdown: nonzero means a load result is not yet usable.
  logic [2:0]           r_sb [NUM_REGS];
  logic [1:0]           r_fwd_rs1_sel;
  logic [1:0]           r_fwd_rs2_sel;
  logic [CPU_WIDTH-1:0] r_redirect_pc;

  logic w_rs1_pend;
  logic w_rs2_pend;
  logic w_lu;
  logic w_busy;
  logic w_redir;
  logic w_lu_stall;
  logic w_sb_set;
  logic w_pc_ena;
  logic w_pc_sel;
  logic w_if_id_stall;
  logic w_if_id_flush;
  logic w_id_ex_stall;
  logic w_id_ex_bubble;
  logic w_ex_mem_bubble;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_WIDTH-1:0] rs,
    input logic                      ex_wen,
    input logic [REG_ADDR_WIDTH-1:0] ex_waddr,
    input logic                      mem_wen,
    input logic [REG_ADDR_WIDTH-1:0] mem_waddr
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != '0) begin
      if (ex_wen && (ex_waddr == rs)) begin
        sel = 2'b01;
      end else if (mem_wen && (mem_waddr == rs)) begin
        sel = 2'b10;
      end
    end
    return sel;
  endfunction

  always_comb begin
    w_rs1_pend = bus.id_rs1_used_i && (r_sb[bus.id_rs1_addr_i] != 3'd0);
    w_rs2_pend = bus.id_rs2_used_i && (r_sb[bus.id_rs2_addr_i] != 3'd0);
    w_lu       = bus.id_valid_i && (w_rs1_pend || w_rs2_pend);
    w_busy     = bus.ex_busy_i;
    // A redirect resolved while EX is busy is not a real event yet.
    w_redir    = bus.redirect_i && !w_busy;
    w_lu_stall = w_lu && !w_busy && !w_redir;
  end

  always_comb begin
    w_pc_ena        = 1'b1;
    w_pc_sel        = 1'b0;
    w_if_id_stall   = 1'b0;
    w_if_id_flush   = 1'b0;
    w_id_ex_stall   = 1'b0;
    w_id_ex_bubble  = 1'b0;
    w_ex_mem_bubble = 1'b0;
    if (w_busy) begin
      w_pc_ena        = 1'b0;
      w_if_id_stall   = 1'b1;
      w_id_ex_stall   = 1'b1;
      w_ex_mem_bubble = 1'b1;
    end else if (w_redir) begin
      // ID holds a wrong-path instruction, so any load-use on it is moot.
      w_pc_sel       = 1'b1;
      w_if_id_flush  = 1'b1;
      w_id_ex_bubble = 1'b1;
    end else if (w_lu) begin
      w_pc_ena       = 1'b0;
      w_if_id_stall  = 1'b1;
      w_id_ex_bubble = 1'b1;
    end
  end

  // The load only reaches EX when ID/EX neither holds nor takes a bubble.
  assign w_sb_set = bus.id_valid_i && bus.id_is_load_i && bus.id_wen_i &&
                    (bus.id_waddr_i != '0) && !w_id_ex_stall && !w_id_ex_bubble;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_sb[i] <= 3'd0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_sb_set && (bus.id_waddr_i == REG_ADDR_WIDTH'(i))) begin
          r_sb[i] <= SB_INIT;
        end else if (r_sb[i] != 3'd0) begin
          r_sb[i] <= r_sb[i] - 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fwd_rs1_sel <= 2'b00;
      r_fwd_rs2_sel <= 2'b00;
    end else if (w_id_ex_stall) begin
      r_fwd_rs1_sel <= r_fwd_rs1_sel;
      r_fwd_rs2_sel <= r_fwd_rs2_sel;
    end else if (w_id_ex_bubble) begin
      r_fwd_rs1_sel <= 2'b00;
      r_fwd_rs2_sel <= 2'b00;
    end else begin
      r_fwd_rs1_sel <= fwd_sel(bus.id_rs1_addr_i, bus.ex_wen_i, bus.ex_waddr_i,
                               bus.mem_wen_i, bus.mem_waddr_i);
      r_fwd_rs2_sel <= fwd_sel(bus.id_rs2_addr_i, bus.ex_wen_i, bus.ex_waddr_i,
                               bus.mem_wen_i, bus.mem_waddr_i);
    end
  end

  // Target is captured only on a real redirect so the trace keeps the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redirect_pc <= '0;
    end else if (w_redir) begin
      r_redirect_pc <= bus.redirect_pc_i;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] r_perf_lu_cnt;
  logic [CNT_WIDTH-1:0] r_perf_fl_cnt;
  logic [CNT_WIDTH-1:0] r_perf_busy_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_lu_cnt   <= '0;
      r_perf_fl_cnt   <= '0;
      r_perf_busy_cnt <= '0;
    end else begin
      if (w_lu_stall && (r_perf_lu_cnt != '1)) begin
        r_perf_lu_cnt <= r_perf_lu_cnt + CNT_WIDTH'(1);
      end
      if (w_redir && (r_perf_fl_cnt != '1)) begin
        r_perf_fl_cnt <= r_perf_fl_cnt + CNT_WIDTH'(1);
      end
      if (w_busy && (r_perf_busy_cnt != '1)) begin
        r_perf_busy_cnt <= r_perf_busy_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.perf_lu_cnt_o   = r_perf_lu_cnt;
  assign bus.perf_fl_cnt_o   = r_perf_fl_cnt;
  assign bus.perf_busy_cnt_o = r_perf_busy_cnt;
`else
  logic w_unused_lu_stall;
  assign w_unused_lu_stall   = w_lu_stall;
  assign bus.perf_lu_cnt_o   = '0;
  assign bus.perf_fl_cnt_o   = '0;
  assign bus.perf_busy_cnt_o = '0;
`endif

  assign bus.pc_ena_o        = w_pc_ena;
  assign bus.pc_sel_o        = w_pc_sel;
  assign bus.redirect_pc_o   = r_redirect_pc;
  assign bus.if_id_stall_o   = w_if_id_stall;
  assign bus.if_id_flush_o   = w_if_id_flush;
  assign bus.id_ex_stall_o   = w_id_ex_stall;
  assign bus.id_ex_bubble_o  = w_id_ex_bubble;
  assign bus.ex_mem_bubble_o = w_ex_mem_bubble;
  assign bus.fwd_rs1_sel_o   = r_fwd_rs1_sel;
  assign bus.fwd_rs2_sel_o   = r_fwd_rs2_sel;
endmodule
